// File: rtl/ldpc_ber_tester_sweep_sched.sv
// rtl/ldpc_ber_tester_sweep_sched.sv - BER tester sweep sequencer driving the generator through a table of points
module ldpc_ber_tester_sweep_sched #(
  parameter int NUM_STEPS     = 8,
  parameter int RST_CYCLES    = 4,
  parameter int DRAIN_TIMEOUT = 4096,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cfg_we,
  input  logic [SW-1:0] i_cfg_addr,
  input  logic [15:0]   i_cfg_factor,
  input  logic [7:0]    i_cfg_offset,
  input  logic [31:0]   i_cfg_ctrl_word,
  input  logic [31:0]   i_cfg_blocks,
  input  logic [SW:0]   i_num_steps,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [63:0]   i_finished_blocks,
  input  logic [31:0]   i_in_flight,
  output logic          o_en,
  output logic          o_sw_resetn,
  output logic [15:0]   o_factor,
  output logic [7:0]    o_offset,
  output logic [31:0]   o_ctrl_word,
  output logic [SW-1:0] o_step_idx,
  output logic          o_busy,
  output logic          o_step_done,
  output logic          o_done,
  output logic          o_aborted,
  output logic          o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SRST, S_RUN, S_DRAIN, S_NEXT, S_FIN
  } state_t;

  localparam logic [SW:0]   NS_ONE  = 1;
  localparam logic [SW-1:0] IDX_ONE = 1;

  logic [15:0]   r_tab_factor [NUM_STEPS];
  logic [7:0]    r_tab_offset [NUM_STEPS];
  logic [31:0]   r_tab_ctrl   [NUM_STEPS];
  logic [31:0]   r_tab_blocks [NUM_STEPS];

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_cnt;
  logic [31:0]   r_target;
  logic [SW:0]   r_num_steps;
  logic [SW-1:0] r_step_idx;
  logic          r_abort_lat;
  logic          r_en, r_sw_resetn, r_busy, r_step_done, r_done, r_aborted, r_timeout;
  logic [15:0]   r_factor;
  logic [7:0]    r_offset;
  logic [31:0]   r_ctrl_word;
  logic          w_reached;
  logic          w_last_step;
  logic          w_timeout_set;

  assign w_reached   = i_finished_blocks >= {32'b0, r_target};
  assign w_last_step = ({1'b0, r_step_idx} == (r_num_steps - NS_ONE));

  // Sweep table: only writable while idle so a running sweep sees stable entries
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && !r_busy) begin
      r_tab_factor[i_cfg_addr] <= i_cfg_factor;
      r_tab_offset[i_cfg_addr] <= i_cfg_offset;
      r_tab_ctrl[i_cfg_addr]   <= i_cfg_ctrl_word;
      r_tab_blocks[i_cfg_addr] <= i_cfg_blocks;
    end
  end

  // Next-state logic; abort short-circuits the active step straight into drain
  always_comb begin
    w_state_next  = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = (i_num_steps == '0) ? S_FIN : S_LOAD;
      S_LOAD:  w_state_next = i_abort ? S_DRAIN : S_SRST;
      S_SRST: begin
        if (i_abort) w_state_next = S_DRAIN;
        else if (r_cnt == 32'(RST_CYCLES - 1)) w_state_next = S_RUN;
      end
      S_RUN:   if (i_abort || w_reached) w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (i_in_flight == 32'd0) begin
          w_state_next = S_NEXT;
        end else if (r_cnt == 32'(DRAIN_TIMEOUT - 1)) begin
          w_state_next  = S_FIN;
          w_timeout_set = 1'b1;
        end
      end
      S_NEXT:  w_state_next = (r_abort_lat || i_abort || w_last_step) ? S_FIN : S_LOAD;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, cycle counter and registered outputs derived from the upcoming state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_target    <= '0;
      r_num_steps <= '0;
      r_step_idx  <= '0;
      r_abort_lat <= 1'b0;
      r_en        <= 1'b0;
      r_sw_resetn <= 1'b1;
      r_busy      <= 1'b0;
      r_step_done <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_timeout   <= 1'b0;
      r_factor    <= '0;
      r_offset    <= '0;
      r_ctrl_word <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= (w_state_next != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_en        <= (w_state_next == S_RUN) && (r_target != 32'd0);
      r_sw_resetn <= (w_state_next != S_SRST);
      r_busy      <= (w_state_next != S_IDLE);
      r_step_done <= (w_state_next == S_NEXT);
      r_done      <= (w_state_next == S_FIN);
      if (r_state == S_IDLE && i_start) begin
        r_num_steps <= i_num_steps;
        r_step_idx  <= '0;
        r_abort_lat <= 1'b0;
        r_aborted   <= 1'b0;
        r_timeout   <= 1'b0;
      end
      // FIN is already ending the sweep, so an abort there has nothing left to stop
      if (i_abort && r_state != S_IDLE && r_state != S_FIN) begin
        r_abort_lat <= 1'b1;
        r_aborted   <= 1'b1;
      end
      if (r_state == S_LOAD) begin
        r_factor    <= r_tab_factor[r_step_idx];
        r_offset    <= r_tab_offset[r_step_idx];
        r_ctrl_word <= r_tab_ctrl[r_step_idx];
        r_target    <= r_tab_blocks[r_step_idx];
      end
      if (r_state == S_NEXT && w_state_next == S_LOAD) r_step_idx <= r_step_idx + IDX_ONE;
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign o_en        = r_en;
  assign o_sw_resetn = r_sw_resetn;
  assign o_factor    = r_factor;
  assign o_offset    = r_offset;
  assign o_ctrl_word = r_ctrl_word;
  assign o_step_idx  = r_step_idx;
  assign o_busy      = r_busy;
  assign o_step_done = r_step_done;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_timeout   = r_timeout;

endmodule
